// File: rtl/wr_ingress_ctrl.sv
// Write-side ingress for an async FIFO: a 2-entry holding buffer that feeds the write port,
// plus an occupancy/almost-full estimate compiled in only when WR_INGRESS_LEVEL_EN is defined.
module wr_ingress_ctrl #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                  w_clk,
  input  logic                  w_rst,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  input  logic                  w_full,
  input  logic [ADDR_WIDTH:0]   w_ptr,
  input  logic [ADDR_WIDTH:0]   r_ptr,
  output logic                  w_en,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic [ADDR_WIDTH:0]   w_level,
  output logic                  w_afull
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] tail_q;
  logic                  push_s;
  logic                  pop_s;

  // Ready is a pure decode of the registered occupancy, so it carries no path from s_valid.
  assign s_ready = !w_rst && ((state_q == ST_EMPTY) || (state_q == ST_ONE));
  assign pop_s   = ((state_q == ST_ONE) || (state_q == ST_TWO)) && !w_full;
  assign push_s  = s_valid && s_ready;
  assign w_en    = pop_s;
  assign w_data  = head_q;

  // Holding-buffer FSM; head_q is always the oldest word, tail_q only valid in ST_TWO.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      state_q <= ST_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (push_s) begin
            head_q  <= s_data;
            state_q <= ST_ONE;
          end else begin
            state_q <= ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (push_s && pop_s) begin
            head_q  <= s_data;
            state_q <= ST_ONE;
          end else if (push_s) begin
            tail_q  <= s_data;
            state_q <= ST_TWO;
          end else if (pop_s) begin
            state_q <= ST_EMPTY;
          end else begin
            state_q <= ST_ONE;
          end
        end
        ST_TWO: begin
          if (pop_s) begin
            head_q  <= tail_q;
            state_q <= ST_ONE;
          end else begin
            state_q <= ST_TWO;
          end
        end
        default: begin
          state_q <= ST_EMPTY;
        end
      endcase
    end
  end

`ifdef WR_INGRESS_LEVEL_EN
  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW:0] AFULL_LVL = (PW + 1)'(AFULL_THRESH);

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0] level_d;
  logic [PW-1:0] level_q;
  logic          afull_d;
  logic          afull_q;

  // Modulo-2^PW subtraction absorbs pointer wrap; the extra pointer bit keeps full distinct from empty.
  always_comb begin
    level_d = gray2bin(w_ptr) - gray2bin(r_ptr);
    afull_d = ({1'b0, level_d} >= AFULL_LVL);
  end

  // Level and almost-full are registered together so they always describe the same sample.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      level_q <= '0;
      afull_q <= 1'b0;
    end else begin
      level_q <= level_d;
      afull_q <= afull_d;
    end
  end

  assign w_level = level_q;
  assign w_afull = afull_q;
`else
  logic unused_ptr_s;
  assign unused_ptr_s = ^{w_ptr, r_ptr};
  assign w_level      = '0;
  assign w_afull      = 1'b0;
`endif

endmodule

// File: tb/tb_wr_ingress_ctrl.sv
// Self-checking bench for wr_ingress_ctrl: queue-based reference model compared every cycle,
// plus directed literal checks for the single-word, back-pressure, streaming, level and reset scenarios.
module tb_wr_ingress_ctrl;

  logic       w_clk = 1'b0;
  logic       w_rst;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic       w_full;
  logic [4:0] w_ptr;
  logic [4:0] r_ptr;
  logic       w_en;
  logic [7:0] w_data;
  logic [4:0] w_level;
  logic       w_afull;

  int errors = 0;
  int checks = 0;

`ifdef WR_INGRESS_LEVEL_EN
  localparam bit LVL_ON = 1'b1;
`else
  localparam bit LVL_ON = 1'b0;
`endif

  wr_ingress_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .AFULL_THRESH(12)) dut (
    .w_clk(w_clk), .w_rst(w_rst), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .w_full(w_full), .w_ptr(w_ptr), .r_ptr(r_ptr), .w_en(w_en), .w_data(w_data),
    .w_level(w_level), .w_afull(w_afull)
  );

  always #5 w_clk = ~w_clk;

  function automatic logic [4:0] b2g(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [4:0] g2b(input logic [4:0] g);
    logic [4:0] b;
    for (int i = 0; i < 5; i++) b[i] = ^(g >> i);
    return b;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the buffer is just an ordered list of at most two words.
  logic [7:0] q[$];
  logic [4:0] exp_level = 5'd0;

  always @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      q.delete();
      exp_level <= 5'd0;
    end else begin
      if (q.size() > 0 && !w_full) begin
        if (s_valid && q.size() < 2) q.push_back(s_data);
        void'(q.pop_front());
      end else if (s_valid && q.size() < 2) begin
        q.push_back(s_data);
      end
      exp_level <= LVL_ON ? (g2b(w_ptr) - g2b(r_ptr)) : 5'd0;
    end
  end

  // Per-cycle comparison against the model, sampled mid-low-phase.
  always @(negedge w_clk) begin
    #2;
    chk("s_ready", 32'(s_ready), 32'(!w_rst && q.size() < 2));
    chk("w_en", 32'(w_en), 32'(!w_rst && q.size() > 0 && !w_full));
    if (!w_rst && q.size() > 0 && !w_full) chk("w_data", 32'(w_data), 32'(q[0]));
    chk("w_level", 32'(w_level), 32'(exp_level));
    chk("w_afull", 32'(w_afull), 32'(LVL_ON && exp_level >= 5'd12));
  end

  task automatic drive(input logic v, input logic [7:0] d, input logic f);
    @(negedge w_clk);
    s_valid = v;
    s_data  = d;
    w_full  = f;
    #3;
  endtask

  initial begin
    w_rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; w_full = 1'b0;
    w_ptr = 5'd0; r_ptr = 5'd0;
    drive(1'b0, 8'h00, 1'b0);
    chk("rst_ready", 32'(s_ready), 32'd0);
    chk("rst_wen", 32'(w_en), 32'd0);
    chk("rst_level", 32'(w_level), 32'd0);
    chk("rst_afull", 32'(w_afull), 32'd0);
    @(negedge w_clk);
    w_rst = 1'b0;
    #3;
    chk("rel_ready", 32'(s_ready), 32'd1);

    // Single word
    drive(1'b1, 8'hA5, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    chk("single_wen", 32'(w_en), 32'd1);
    chk("single_data", 32'(w_data), 32'hA5);
    drive(1'b0, 8'h00, 1'b0);
    chk("single_idle", 32'(w_en), 32'd0);

    // Back-pressure
    drive(1'b1, 8'h01, 1'b1);
    drive(1'b1, 8'h02, 1'b1);
    drive(1'b0, 8'h00, 1'b1);
    chk("bp_ready_low", 32'(s_ready), 32'd0);
    chk("bp_wen_low", 32'(w_en), 32'd0);
    drive(1'b0, 8'h00, 1'b0);
    chk("bp_wen1", 32'(w_en), 32'd1);
    chk("bp_data1", 32'(w_data), 32'h01);
    drive(1'b0, 8'h00, 1'b0);
    chk("bp_wen2", 32'(w_en), 32'd1);
    chk("bp_data2", 32'(w_data), 32'h02);
    drive(1'b0, 8'h00, 1'b0);
    chk("bp_done_wen", 32'(w_en), 32'd0);
    chk("bp_done_ready", 32'(s_ready), 32'd1);

    // Streaming 0..31 with no back-pressure
    for (int i = 0; i <= 32; i++) begin
      drive(i < 32, 8'(i), 1'b0);
      chk("stream_ready", 32'(s_ready), 32'd1);
      if (i > 0) begin
        chk("stream_wen", 32'(w_en), 32'd1);
        chk("stream_data", 32'(w_data), 32'(i - 1));
      end
    end
    drive(1'b0, 8'h00, 1'b0);
    chk("stream_idle", 32'(w_en), 32'd0);

    // Level wrap and almost-full
    w_ptr = b2g(5'd3); r_ptr = b2g(5'd29);
    drive(1'b0, 8'h00, 1'b0);
    chk("lvl_wrap", 32'(w_level), LVL_ON ? 32'd6 : 32'd0);
    chk("lvl_wrap_afull", 32'(w_afull), 32'd0);
    w_ptr = b2g(5'd12); r_ptr = b2g(5'd0);
    drive(1'b0, 8'h00, 1'b0);
    chk("lvl_12", 32'(w_level), LVL_ON ? 32'd12 : 32'd0);
    chk("lvl_12_afull", 32'(w_afull), LVL_ON ? 32'd1 : 32'd0);

    // Mid-operation reset with the buffer full and stalled
    w_ptr = b2g(5'd5); r_ptr = b2g(5'd0);
    drive(1'b1, 8'h11, 1'b1);
    drive(1'b1, 8'h22, 1'b1);
    drive(1'b0, 8'h00, 1'b1);
    chk("mid_two_ready", 32'(s_ready), 32'd0);
    chk("mid_level_pre", 32'(w_level), LVL_ON ? 32'd5 : 32'd0);
    @(negedge w_clk);
    #1 w_rst = 1'b1;
    #2;
    chk("mid_rst_wen", 32'(w_en), 32'd0);
    chk("mid_rst_level", 32'(w_level), 32'd0);
    chk("mid_rst_ready", 32'(s_ready), 32'd0);
    @(negedge w_clk);
    w_rst = 1'b0; w_full = 1'b0;
    #3;
    chk("mid_rel_ready", 32'(s_ready), 32'd1);
    chk("mid_rel_wen", 32'(w_en), 32'd0);

    // Randomized traffic, back-pressure and legal pointer pairs
    repeat (400) begin
      logic [4:0] wb;
      wb = 5'($urandom_range(0, 31));
      @(negedge w_clk);
      s_valid = 1'($urandom_range(0, 1));
      s_data  = 8'($urandom);
      w_full  = ($urandom_range(0, 3) == 0);
      w_ptr   = b2g(wb);
      r_ptr   = b2g(wb - 5'($urandom_range(0, 16)));
    end
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    drive(1'b0, 8'h00, 1'b0);
    chk("final_empty_wen", 32'(w_en), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
